// File: rtl/path_launch_capture_if.sv
// Handshake/bus bundle for the launch/capture controller.
// master: the side that starts bursts and closes the path loop (bench / test wrapper).
// slave: the controller itself.
interface path_launch_capture_if #(
  parameter int N_WIDTH   = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [N_WIDTH-1:0]   num_tests;
  logic                 path_y;
  logic                 path_a;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] pass_cnt;
  logic [CNT_WIDTH-1:0] fail_cnt;
  logic                 any_fail;

  modport master (
    output start, num_tests, path_y,
    input  path_a, busy, done, pass_cnt, fail_cnt, any_fail
  );

  modport slave (
    input  start, num_tests, path_y,
    output path_a, busy, done, pass_cnt, fail_cnt, any_fail
  );
endinterface

// File: rtl/path_launch_capture.sv
// Launch/capture controller for at-speed transition testing of one
// combinational path. path_a launches a transition, path_y is sampled
// CAP_DELAY cycles later and compared with the expected level. A burst of
// alternating rise/fall launches runs back to back, accumulating saturating
// pass/fail counts.
module path_launch_capture #(
  parameter int CAP_DELAY      = 2,
  parameter int N_WIDTH        = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int PATH_INVERTING = 0
) (
  input logic                   C,
  input logic                   R,
  path_launch_capture_if.slave  bus
);

  // Capture window must fit the 4-bit wait counter and be at least one cycle.
  if (CAP_DELAY < 1 || CAP_DELAY > 15) begin : g_bad_cap_delay
    $error("path_launch_capture: CAP_DELAY must be in 1..15");
  end

  localparam logic [3:0] RELOAD = 4'(CAP_DELAY - 1);
  localparam logic       INV    = (PATH_INVERTING != 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  logic                 r_path_a;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_pass_cnt;
  logic [CNT_WIDTH-1:0] r_fail_cnt;
  logic                 r_any_fail;
  logic [N_WIDTH-1:0]   r_remaining;
  logic [3:0]           r_wait_cnt;
  logic                 w_match;

  // Pre-edge comparison: path_a still holds the level launched for this capture.
  assign w_match = (bus.path_y == (r_path_a ^ INV));

  // Burst sequencer: launch, count down the capture window, score, relaunch.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state     <= S_IDLE;
      r_path_a    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_any_fail  <= 1'b0;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_any_fail <= 1'b0;
            if (bus.num_tests != '0) begin
              r_path_a    <= ~r_path_a;
              r_remaining <= bus.num_tests;
              r_wait_cnt  <= RELOAD;
              r_busy      <= 1'b1;
              r_state     <= S_WAIT;
            end else begin
              // Empty burst: no launch, just the completion pulse.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else begin
            if (w_match) begin
              if (r_pass_cnt != {CNT_WIDTH{1'b1}}) r_pass_cnt <= r_pass_cnt + CNT_WIDTH'(1);
            end else begin
              if (r_fail_cnt != {CNT_WIDTH{1'b1}}) r_fail_cnt <= r_fail_cnt + CNT_WIDTH'(1);
              r_any_fail <= 1'b1;
            end
            r_remaining <= r_remaining - N_WIDTH'(1);
            if (r_remaining == N_WIDTH'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Next launch shares the capture edge, so the period is CAP_DELAY.
              r_path_a   <= ~r_path_a;
              r_wait_cnt <= RELOAD;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.path_a   = r_path_a;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
  assign bus.any_fail = r_any_fail;

endmodule

// File: tb/tb_path_launch_capture.sv
// Bench for path_launch_capture. Three instances share clock, reset and the
// start/num_tests stimulus, each with different CAP_DELAY / inversion / counter
// width, and each closed through its own modelled path (delay in cycles,
// optional inversion). Expected results come from a timeline model of launches.
module tb_path_launch_capture;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_tests = 8'd0;

  always #5 C = ~C;

  int cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  function automatic int dv(input int i);
    case (i) 0: return 2; 1: return 1; default: return 3; endcase
  endfunction
  function automatic bit piv(input int i);
    return (i == 1);
  endfunction
  function automatic int wv(input int i);
    return (i == 2) ? 2 : 8;
  endfunction

  logic       pa[3], bz[3], dn[3], af[3], py[3];
  logic [7:0] pc[3], fc[3];
  logic [3:0] h[3];
  int         lat[3];
  bit         inv[3];

  // Path model: lat cycles of register delay (0 = zero-delay wire), then inversion.
  always @(posedge C) for (int i = 0; i < 3; i++) h[i] <= {h[i][2:0], pa[i]};
  for (genvar g = 0; g < 3; g++) begin : g_path
    assign py[g] = ((lat[g] == 0) ? pa[g] : h[g][2'(lat[g] - 1)]) ^ inv[g];
  end

  path_launch_capture_if #(.N_WIDTH(8), .CNT_WIDTH(8)) if0 ();
  path_launch_capture_if #(.N_WIDTH(8), .CNT_WIDTH(8)) if1 ();
  path_launch_capture_if #(.N_WIDTH(8), .CNT_WIDTH(2)) if2 ();

  assign if0.start = start; assign if0.num_tests = num_tests; assign if0.path_y = py[0];
  assign if1.start = start; assign if1.num_tests = num_tests; assign if1.path_y = py[1];
  assign if2.start = start; assign if2.num_tests = num_tests; assign if2.path_y = py[2];
  assign pa[0] = if0.path_a; assign bz[0] = if0.busy; assign dn[0] = if0.done;
  assign af[0] = if0.any_fail; assign pc[0] = if0.pass_cnt; assign fc[0] = if0.fail_cnt;
  assign pa[1] = if1.path_a; assign bz[1] = if1.busy; assign dn[1] = if1.done;
  assign af[1] = if1.any_fail; assign pc[1] = if1.pass_cnt; assign fc[1] = if1.fail_cnt;
  assign pa[2] = if2.path_a; assign bz[2] = if2.busy; assign dn[2] = if2.done;
  assign af[2] = if2.any_fail; assign pc[2] = {6'd0, if2.pass_cnt}; assign fc[2] = {6'd0, if2.fail_cnt};

  path_launch_capture #(.CAP_DELAY(2), .N_WIDTH(8), .CNT_WIDTH(8), .PATH_INVERTING(0))
    u0 (.C(C), .R(R), .bus(if0));
  path_launch_capture #(.CAP_DELAY(1), .N_WIDTH(8), .CNT_WIDTH(8), .PATH_INVERTING(1))
    u1 (.C(C), .R(R), .bus(if1));
  path_launch_capture #(.CAP_DELAY(3), .N_WIDTH(8), .CNT_WIDTH(2), .PATH_INVERTING(0))
    u2 (.C(C), .R(R), .bus(if2));

  // Cumulative activity monitor, sampled mid-cycle.
  int   bcnt[3], dcnt[3], dcyc[3], tog[3];
  logic lpa[3];
  always @(negedge C) begin
    for (int i = 0; i < 3; i++) begin
      if (bz[i] === 1'b1) bcnt[i] <= bcnt[i] + 1;
      if (dn[i] === 1'b1) begin dcnt[i] <= dcnt[i] + 1; dcyc[i] <= cyc; end
      if (pa[i] !== lpa[i]) tog[i] <= tog[i] + 1;
      lpa[i] <= pa[i];
    end
  end

  int checks = 0;
  int errors = 0;
  bit mp0[3];   // modelled path_a level before the next burst

  // path_a level after edge e for a burst starting at edge s.
  function automatic bit ahist(input int e, input int s, input int n, input int d, input bit p0);
    int k;
    if (e < s || n == 0) return p0;
    k = (e - s) / d + 1;
    if (k > n) k = n;
    return p0 ^ k[0];
  endfunction

  task automatic set_path(input int l, input bit flip);
    for (int i = 0; i < 3; i++) begin lat[i] = l; inv[i] = piv(i) ^ flip; end
  endtask

  task automatic run_burst(input int n, input int hold, input string tag);
    int b0[3], d0[3], t0[3];
    int s, d, pe, fe, cap, epc, efc, c;
    bit ea, y, efa;
    @(posedge C); #1;
    for (int i = 0; i < 3; i++) begin b0[i] = bcnt[i]; d0[i] = dcnt[i]; t0[i] = tog[i]; end
    @(negedge C); start = 1'b1; num_tests = 8'(n);
    @(posedge C); #1; s = cyc;
    repeat (hold) begin @(negedge C); num_tests = 8'($urandom); end
    @(negedge C); start = 1'b0; num_tests = 8'($urandom);
    repeat (3 * n + 6) @(posedge C);
    #1;
    for (int i = 0; i < 3; i++) begin
      d = dv(i); pe = 0; fe = 0;
      for (int j = 1; j <= n; j++) begin
        c  = s + d * j;
        ea = ahist(c - 1, s, n, d, mp0[i]);
        y  = ahist(c - 1 - lat[i], s, n, d, mp0[i]) ^ inv[i];
        if (y == (ea ^ piv(i))) pe++; else fe++;
      end
      cap = (1 << wv(i)) - 1;
      epc = (pe > cap) ? cap : pe;
      efc = (fe > cap) ? cap : fe;
      efa = mp0[i] ^ n[0];
      checks++; if (pc[i] !== 8'(epc)) begin errors++;
        $display("FAIL %s u%0d pass_cnt got %0d exp %0d", tag, i, pc[i], epc); end
      checks++; if (fc[i] !== 8'(efc)) begin errors++;
        $display("FAIL %s u%0d fail_cnt got %0d exp %0d", tag, i, fc[i], efc); end
      checks++; if (af[i] !== (fe > 0)) begin errors++;
        $display("FAIL %s u%0d any_fail got %b exp %b", tag, i, af[i], fe > 0); end
      checks++; if (pa[i] !== efa) begin errors++;
        $display("FAIL %s u%0d path_a got %b exp %b", tag, i, pa[i], efa); end
      checks++; if (tog[i] - t0[i] != n) begin errors++;
        $display("FAIL %s u%0d launches got %0d exp %0d", tag, i, tog[i] - t0[i], n); end
      checks++; if (bcnt[i] - b0[i] != d * n) begin errors++;
        $display("FAIL %s u%0d busy cycles got %0d exp %0d", tag, i, bcnt[i] - b0[i], d * n); end
      checks++; if (dcnt[i] - d0[i] != 1) begin errors++;
        $display("FAIL %s u%0d done pulses got %0d exp 1", tag, i, dcnt[i] - d0[i]); end
      checks++; if (dcyc[i] != s + d * n) begin errors++;
        $display("FAIL %s u%0d done edge got %0d exp %0d", tag, i, dcyc[i] - s, d * n); end
      mp0[i] = efa;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pa[i], bz[i], dn[i], af[i], pc[i], fc[i]} !== 20'd0) begin errors++;
        $display("FAIL %s u%0d outputs got a=%b busy=%b done=%b af=%b p=%0d f=%0d exp all 0",
                 tag, i, pa[i], bz[i], dn[i], af[i], pc[i], fc[i]);
      end
    end
  endtask

  task automatic test_reset();
    R = 1'b1; start = 1'b1; num_tests = 8'd5;
    repeat (4) @(posedge C);
    #1 check_zero("reset_held");
    @(negedge C); start = 1'b0; R = 1'b0;
    repeat (4) @(posedge C);
    #1 check_zero("reset_released");
  endtask

  task automatic test_buffer();     set_path(0, 1'b0); run_burst(4, 0, "buffer");    endtask
  task automatic test_slow();       set_path(3, 1'b0); run_burst(3, 0, "slow");      endtask
  task automatic test_inverting();  set_path(0, 1'b0); run_burst(5, 2, "inverting"); endtask
  task automatic test_zero();       set_path(1, 1'b0); run_burst(0, 1, "zero");      endtask
  task automatic test_saturation(); set_path(0, 1'b0); run_burst(6, 0, "saturate");  endtask

  task automatic test_abort();
    int d0[3], s;
    set_path(0, 1'b0);
    @(posedge C); #1;
    for (int i = 0; i < 3; i++) d0[i] = dcnt[i];
    @(negedge C); start = 1'b1; num_tests = 8'd8;
    @(posedge C); #1; s = cyc;
    @(negedge C); start = 1'b0;
    while (cyc < s + 4) @(posedge C);
    #1;
    checks++; if (pc[0] !== 8'd2) begin errors++;
      $display("FAIL abort pre-reset u0 pass_cnt got %0d exp 2", pc[0]); end
    @(negedge C); R = 1'b1;
    #1 check_zero("abort_immediate");
    repeat (3) @(posedge C);
    #1 check_zero("abort_held");
    @(negedge C); R = 1'b0;
    repeat (2) @(posedge C);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dcnt[i] != d0[i]) begin errors++;
        $display("FAIL abort u%0d done pulses got %0d exp 0", i, dcnt[i] - d0[i]); end
      mp0[i] = 1'b0;
    end
    repeat (4) @(posedge C);
  endtask

  task automatic test_random();
    int n, hold;
    for (int k = 0; k < 20; k++) begin
      n    = $urandom_range(0, 12);
      hold = $urandom_range(0, n + 1);
      for (int i = 0; i < 3; i++) begin
        lat[i] = $urandom_range(0, 3);
        inv[i] = piv(i) ^ ($urandom_range(0, 3) == 0);
      end
      run_burst(n, hold, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin lat[i] = 0; inv[i] = piv(i); mp0[i] = 1'b0; end
    test_reset();
    test_buffer();
    test_slow();
    test_inverting();
    test_zero();
    test_saturation();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
